cpu_clk_ctrl: RTL and testbench

//   Run/step/halt controller for the CPU clock. Emits a one-cycle clock-enable pulse (cpu_tick).

---
 rtl/cpu_clk_ctrl_pkg.sv | 25 ++
 rtl/cpu_clk_ctrl_btn_edge.sv | 77 +++++++
 rtl/cpu_clk_ctrl.sv | 156 +++++++++++++++
 tb/tb_cpu_clk_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_clk_ctrl_pkg.sv
// cpu_clk_ctrl_pkg
//   Shared definitions for the CPU clock controller: FSM state encoding
//   (also driven out on state_o), rate_sel encodings and the default
//   clk-cycles-per-tick constants.
//   No ports (package).
package cpu_clk_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  localparam logic [1:0] RATE_FAST = 2'd0;
  localparam logic [1:0] RATE_MID  = 2'd1;
  localparam logic [1:0] RATE_SLOW = 2'd2;  // 2'd3 also selects the slow rate

  localparam int CNT_W_DEF     = 32;
  localparam int N_FAST_DEF    = 2;
  localparam int N_MID_DEF     = 5_000_000;
  localparam int N_SLOW_DEF    = 50_000_000;
  localparam int DB_CYCLES_DEF = 1_000_000;

endpackage

// File: rtl/cpu_clk_ctrl_btn_edge.sv
// btn_edge
//   Conditions one raw board button: 2-flop synchroniser, optional
//   debounce, then rising-edge detect on the accepted level.
//   Optional feature macro: DEBOUNCE_EN (level accepted only after
//   DB_CYCLES consecutive equal synchronised samples).
// Ports
//   clk     in  1  system clock
//   rst_n   in  1  asynchronous active-low reset
//   btn_i   in  1  raw asynchronous button level
//   edge_o  out 1  high for one cycle on each accepted rising edge
module btn_edge #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic edge_o
);

  logic sync1_q;
  logic sync2_q;
  logic level_s;
  logic prev_q;

  // Two-flop synchroniser for the asynchronous button input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

  logic           db_q;
  logic [DBW-1:0] db_cnt_q;

  // Debounce: the accepted level follows the synchronised level only after
  // it has differed from the accepted level for DB_CYCLES samples in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q     <= 1'b0;
      db_cnt_q <= {DBW{1'b0}};
    end else if (sync2_q != db_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_q     <= sync2_q;
        db_cnt_q <= {DBW{1'b0}};
      end else begin
        db_cnt_q <= db_cnt_q + {{(DBW-1){1'b0}}, 1'b1};
      end
    end else begin
      db_cnt_q <= {DBW{1'b0}};
    end
  end

  assign level_s = db_q;
`else
  assign level_s = sync2_q;
`endif

  // Previous accepted level for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= level_s;
    end
  end

  assign edge_o = level_s & ~prev_q;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl
//   Run/step/halt controller for the CPU clock. Emits a registered
//   one-cycle clock-enable pulse (cpu_tick) at a runtime-selectable
//   period, handles pause/resume/single-step buttons and the CPU halt
//   request, and counts issued ticks. clr acts as the synchronous clear.
//   Optional feature macro: DEBOUNCE_EN (button debounce in btn_edge).
// Ports
//   clk          in  1      system clock
//   rst_n        in  1      asynchronous active-low reset
//   start        in  1      level; IDLE->RUN
//   clr          in  1      synchronous clear to IDLE, counters zeroed
//   pause_btn    in  1      raw button; accepted rising edge toggles RUN/PAUSE
//   step_btn     in  1      raw button; accepted rising edge in PAUSE = one tick
//   halt         in  1      CPU halt request
//   rate_sel     in  2      0 fast, 1 mid, 2/3 slow
//   cpu_tick     out 1      one-cycle clock enable
//   state_o      out 2      IDLE=0 RUN=1 PAUSE=2 HALT=3
//   cycle_count  out CNT_W  ticks issued since reset/clr (wrapping)
module cpu_clk_ctrl
  import cpu_clk_ctrl_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int N_FAST    = N_FAST_DEF,
  parameter int N_MID     = N_MID_DEF,
  parameter int N_SLOW    = N_SLOW_DEF,
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clr,
  input  logic             pause_btn,
  input  logic             step_btn,
  input  logic             halt,
  input  logic [1:0]       rate_sel,
  output logic             cpu_tick,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] cycle_count
);

  localparam logic [CNT_W-1:0] TC_FAST = CNT_W'(N_FAST - 1);
  localparam logic [CNT_W-1:0] TC_MID  = CNT_W'(N_MID - 1);
  localparam logic [CNT_W-1:0] TC_SLOW = CNT_W'(N_SLOW - 1);
  localparam logic [CNT_W-1:0] ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] tc_s;
  logic             pause_edge_s;
  logic             step_edge_s;

  btn_edge #(.DB_CYCLES(DB_CYCLES)) u_pause_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (pause_btn),
    .edge_o (pause_edge_s)
  );

  btn_edge #(.DB_CYCLES(DB_CYCLES)) u_step_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (step_btn),
    .edge_o (step_edge_s)
  );

  // Terminal count for the selected rate.
  always_comb begin
    tc_s = TC_SLOW;
    case (rate_sel)
      RATE_FAST: tc_s = TC_FAST;
      RATE_MID:  tc_s = TC_MID;
      default:   tc_s = TC_SLOW;
    endcase
  end

  // Next-state logic: FSM, divider, tick and tick counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    count_d = count_q + (tick_q ? ONE : ZERO);
    if (clr) begin
      state_d = ST_IDLE;
      cnt_d   = ZERO;
      count_d = ZERO;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d = ZERO;
          if (start) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (halt) begin
            // Halt wins over a coincident terminal count: no tick.
            state_d = ST_HALT;
            cnt_d   = ZERO;
          end else if (pause_edge_s) begin
            state_d = ST_PAUSE;  // cnt frozen until RUN resumes
          end else if (cnt_q >= tc_s) begin
            // >= so a lowered rate mid-count ticks at once instead of wrapping.
            cnt_d  = ZERO;
            tick_d = 1'b1;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        ST_PAUSE: begin
          if (halt) begin
            state_d = ST_HALT;
            cnt_d   = ZERO;
          end else if (pause_edge_s) begin
            state_d = ST_RUN;
          end else if (step_edge_s && !tick_q) begin
            tick_d = 1'b1;  // single step; never back-to-back
          end else begin
            state_d = ST_PAUSE;
          end
        end
        ST_HALT: begin
          cnt_d = ZERO;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = ZERO;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= ZERO;
      count_q <= ZERO;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign cpu_tick    = tick_q;
  assign state_o     = state_q;
  assign cycle_count = count_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
module tb_cpu_clk_ctrl;

  localparam int CNT_W = 8;
  localparam int DB    = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             clr = 1'b0;
  logic             pause_btn = 1'b0;
  logic             step_btn = 1'b0;
  logic             halt = 1'b0;
  logic [1:0]       rate_sel = 2'd0;
  logic             cpu_tick;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] cycle_count;

  int n_err = 0;
  int n_chk = 0;

  // Reference model (spec-level, plain integers)
  int m_state = 0;   // 0 IDLE 1 RUN 2 PAUSE 3 HALT
  int m_cnt   = 0;
  int m_tick  = 0;
  int m_count = 0;
  bit [3:0] hp = '0;  // raw pause samples, [0] = newest edge
  bit [3:0] hs = '0;
  int acc [2];        // debounced levels (DEBOUNCE_EN)
  int accp[2];
  int run [2];
  int obs_ticks = 0;

  cpu_clk_ctrl #(
    .CNT_W(CNT_W), .N_FAST(2), .N_MID(4), .N_SLOW(8), .DB_CYCLES(DB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clr(clr),
    .pause_btn(pause_btn), .step_btn(step_btn), .halt(halt),
    .rate_sel(rate_sel), .cpu_tick(cpu_tick), .state_o(state_o),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  function automatic int period(input logic [1:0] rs);
    if (rs == 2'd0) return 2;
    else if (rs == 2'd1) return 4;
    else return 8;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    int pe, se, nt, cnt_period;
    if (!rst_n) begin
      m_state = 0; m_cnt = 0; m_tick = 0; m_count = 0;
      hp = '0; hs = '0;
      for (int b = 0; b < 2; b++) begin acc[b] = 0; accp[b] = 0; run[b] = 0; end
      return;
    end
    hp = {hp[2:0], pause_btn};
    hs = {hs[2:0], step_btn};
`ifdef DEBOUNCE_EN
    // Accepted level changes after DB consecutive differing synchronised samples;
    // the synchronised level seen now is the raw level of two edges ago.
    pe = (acc[0] == 1 && accp[0] == 0) ? 1 : 0;
    se = (acc[1] == 1 && accp[1] == 0) ? 1 : 0;
    for (int b = 0; b < 2; b++) begin
      int s;
      s = (b == 0) ? int'(hp[2]) : int'(hs[2]);
      accp[b] = acc[b];
      if (s != acc[b]) begin
        run[b]++;
        if (run[b] == DB) begin acc[b] = s; run[b] = 0; end
      end else begin
        run[b] = 0;
      end
    end
`else
    // Press first sampled at edge k is acted on at edge k+2.
    pe = (hp[2] && !hp[3]) ? 1 : 0;
    se = (hs[2] && !hs[3]) ? 1 : 0;
`endif
    cnt_period = period(rate_sel);
    nt = 0;
    if (clr) begin
      m_count = 0; m_state = 0; m_cnt = 0;
    end else begin
      m_count = (m_count + m_tick) % (1 << CNT_W);
      if (m_state == 0) begin
        m_cnt = 0;
        if (start) m_state = 1;
      end else if (m_state == 1) begin
        if (halt) begin m_state = 3; m_cnt = 0; end
        else if (pe != 0) m_state = 2;
        else if (m_cnt >= cnt_period - 1) begin m_cnt = 0; nt = 1; end
        else m_cnt++;
      end else if (m_state == 2) begin
        if (halt) begin m_state = 3; m_cnt = 0; end
        else if (pe != 0) m_state = 1;
        else if (se != 0 && m_tick == 0) nt = 1;
      end else begin
        m_cnt = 0;
      end
    end
    m_tick = nt;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_update();
    #1;
    chk("tick", 32'(cpu_tick), 32'(m_tick));
    chk("state", 32'(state_o), 32'(m_state));
    chk("count", 32'(cycle_count), 32'(m_count));
    if (cpu_tick === 1'b1) obs_ticks++;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic press(input bit is_step, input int hi, input int lo);
    if (is_step) step_btn = 1'b1; else pause_btn = 1'b1;
    cycles(hi);
    if (is_step) step_btn = 1'b0; else pause_btn = 1'b0;
    cycles(lo);
  endtask

  initial begin
    int c0;
    bit found;

    // Reset state
    cycles(3);
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_count", 32'(cycle_count), 32'd0);
    rst_n = 1'b1;
    start = 1'b1;
    rate_sel = 2'd0;
    cycles(12);

    // 1: asynchronous reset mid-RUN clears outputs immediately
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_async_tick", 32'(cpu_tick), 32'd0);
    chk("t1_async_state", 32'(state_o), 32'd0);
    chk("t1_async_count", 32'(cycle_count), 32'd0);
    cycles(2);
    rst_n = 1'b1;
    obs_ticks = 0;
    cycles(21);
    chk("t1_fast_ticks", 32'(obs_ticks), 32'd10);

    // 2: slow rate, lower to fast when cnt reaches 6
    rate_sel = 2'd2;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc();
      if (m_state == 1 && m_cnt == 6) found = 1'b1;
    end
    chk("t2_reach_cnt6", 32'(found), 32'd1);
    rate_sel = 2'd0;
    cyc();
    chk("t2_tick_next", 32'(cpu_tick), 32'd1);
    cycles(8);

    // 3: pause, then three single steps
    press(1'b0, 2, 6);
    chk("t3_paused", 32'(state_o), 32'd2);
    c0 = m_count;
    obs_ticks = 0;
    for (int k = 0; k < 3; k++) press(1'b1, 2, 4);
    cycles(2);
    chk("t3_step_ticks", 32'(obs_ticks), 32'd3);
    chk("t3_count_plus3", 32'(cycle_count), 32'((c0 + 3) % (1 << CNT_W)));
    press(1'b0, 2, 4);
    chk("t3_resumed", 32'(state_o), 32'd1);

    // Randomized phase: rate changes and button activity
    for (int i = 0; i < 200; i++) begin
      if (i % 25 == 0) rate_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) pause_btn = ~pause_btn;
      if ($urandom_range(0, 3) == 0) step_btn = ~step_btn;
      cyc();
    end
    pause_btn = 1'b0;
    step_btn = 1'b0;
    cycles(DB + 6);

    // 4: halt coincident with a pause edge -> HALT, sticky until clr
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("t4_clr_idle", 32'(state_o), 32'd0);
    rate_sel = 2'd0;
    cycles(5);
    pause_btn = 1'b1;
    cycles(2);
    halt = 1'b1;
    cyc();
    chk("t4_halted", 32'(state_o), 32'd3);
    chk("t4_no_tick", 32'(cpu_tick), 32'd0);
    pause_btn = 1'b0;
    halt = 1'b0;
    obs_ticks = 0;
    cycles(4);
    press(1'b0, 2, 4);
    chk("t4_sticky", 32'(state_o), 32'd3);
    chk("t4_halt_ticks", 32'(obs_ticks), 32'd0);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("t4_clr_state", 32'(state_o), 32'd0);
    chk("t4_clr_count", 32'(cycle_count), 32'd0);

    // 5: cycle_count wraps from 2^CNT_W-1 to 0
    found = 1'b0;
    for (int i = 0; i < 700 && !found; i++) begin
      cyc();
      if (m_count == (1 << CNT_W) - 1) found = 1'b1;
    end
    chk("t5_reach_max", 32'(found), 32'd1);
    chk("t5_at_max", 32'(cycle_count), 32'((1 << CNT_W) - 1));
    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      cyc();
      if (m_count == 0) found = 1'b1;
    end
    chk("t5_wrapped_seen", 32'(found), 32'd1);
    chk("t5_wrap_zero", 32'(cycle_count), 32'd0);

`ifdef DEBOUNCE_EN
    // 6: short glitch ignored, long press toggles once
    press(1'b0, 2, 12);
    chk("t6_glitch", 32'(state_o), 32'd1);
    press(1'b0, 6, 12);
    chk("t6_toggle", 32'(state_o), 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
